// File: rtl/bcp_pkg.sv
// Shared types and sizing for the BCP assignment trail: entry layout, FSM states, widths.
package bcp_pkg;

   localparam int FORMULA_MAX_VARIABLE  = 20;
   localparam int VARIABLE_ENCODING_LEN = $clog2(FORMULA_MAX_VARIABLE + 1);
   localparam int LEVEL_LEN             = $clog2(FORMULA_MAX_VARIABLE + 1);
   localparam int TRAIL_DEPTH           = FORMULA_MAX_VARIABLE;
   localparam int DEPTH_LEN             = $clog2(TRAIL_DEPTH + 1);

   typedef struct packed {
      logic [VARIABLE_ENCODING_LEN-1:0] var_id;
      logic                             value;
      logic                             is_decision;
      logic [LEVEL_LEN-1:0]             level;
   } trail_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      DONE = 2'd2
   } trail_state_t;

endpackage

// File: rtl/bcp_trail_stack.sv
// Register-array LIFO holding the assignment trail; top entry is readable combinationally.
// Push on a full stack and pop on an empty stack are ignored; the controller never issues both together.
module bcp_trail_stack
   import bcp_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  trail_entry_t         push_entry,
   input  logic                 pop,
   output trail_entry_t         top,
   output logic [DEPTH_LEN-1:0] depth,
   output logic                 full
);

   trail_entry_t         mem [TRAIL_DEPTH];
   logic [DEPTH_LEN-1:0] count;

   assign full  = (count == DEPTH_LEN'(TRAIL_DEPTH));
   assign depth = count;
   assign top   = (count != '0) ? mem[count - 1'b1] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + 1'b1;
      end else if (pop && count != '0) begin
         count <= count - 1'b1;
      end
   end

   // Storage is not reset: entries above the count are never observed.
   always_ff @(posedge clk) begin
      if (!rst && push && !full) begin
         mem[count] <= push_entry;
      end
   end

endmodule

// File: rtl/bcp_trail_controller.sv
// Trail recorder and backtrack sequencer: one unassign per cycle while the top entry is above target,
// then a one-cycle done pulse carrying the lowest-level decision popped. Pushes outside IDLE or when full are dropped.
module bcp_trail_controller
   import bcp_pkg::*;
(
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             push_valid_i,
   input  logic [VARIABLE_ENCODING_LEN-1:0] push_var_id_i,
   input  logic                             push_value_i,
   input  logic                             push_is_decision_i,
   output logic                             push_ready_o,
   input  logic                             backtrack_req_i,
   input  logic [LEVEL_LEN-1:0]             backtrack_level_i,
   output logic                             unassign_valid_o,
   output logic [VARIABLE_ENCODING_LEN-1:0] unassign_var_id_o,
   output logic                             backtrack_done_o,
   output logic                             flip_valid_o,
   output logic [VARIABLE_ENCODING_LEN-1:0] flip_var_id_o,
   output logic                             flip_value_o,
   output logic                             busy_o,
   output logic [LEVEL_LEN-1:0]             current_level_o,
   output logic [DEPTH_LEN-1:0]             depth_o,
   output logic                             full_o,
   output logic                             overflow_o
);

   trail_state_t                     state;
   logic [LEVEL_LEN-1:0]             level;
   logic [LEVEL_LEN-1:0]             target;
   logic                             overflow;
   logic                             flip_valid;
   logic [VARIABLE_ENCODING_LEN-1:0] flip_var;
   logic                             flip_value;

   trail_entry_t                     top;
   trail_entry_t                     push_entry;
   logic [DEPTH_LEN-1:0]             depth;
   logic                             full;
   logic                             push_ok;
   logic                             pop_ok;

   always_comb begin
      push_ok = (state == IDLE) && push_valid_i && !full &&
                !(push_is_decision_i && level == LEVEL_LEN'(FORMULA_MAX_VARIABLE));
      pop_ok  = (state == POP) && (depth != '0) && (top.level > target);
      push_entry.var_id      = push_var_id_i;
      push_entry.value       = push_value_i;
      push_entry.is_decision = push_is_decision_i;
      push_entry.level       = push_is_decision_i ? level + 1'b1 : level;
   end

   bcp_trail_stack u_stack (
      .clk        (clk_i),
      .rst        (rst_i),
      .push       (push_ok),
      .push_entry (push_entry),
      .pop        (pop_ok),
      .top        (top),
      .depth      (depth),
      .full       (full)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         level      <= '0;
         target     <= '0;
         overflow   <= 1'b0;
         flip_valid <= 1'b0;
         flip_var   <= '0;
         flip_value <= 1'b0;
      end else begin
         if (push_valid_i && !push_ok) begin
            overflow <= 1'b1;
         end
         if (push_ok && push_is_decision_i) begin
            level <= level + 1'b1;
         end
         case (state)
            IDLE: begin
               if (backtrack_req_i) begin
                  target     <= backtrack_level_i;
                  flip_valid <= 1'b0;
                  state      <= POP;
               end
            end
            POP: begin
               // Pops run in descending level order, so the last decision seen is the lowest-level one.
               if (pop_ok) begin
                  if (top.is_decision) begin
                     flip_valid <= 1'b1;
                     flip_var   <= top.var_id;
                     flip_value <= top.value;
                  end
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (target < level) begin
                  level <= target;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign unassign_valid_o  = pop_ok;
   assign unassign_var_id_o = pop_ok ? top.var_id : '0;
   assign backtrack_done_o  = (state == DONE);
   assign flip_valid_o      = (state == DONE) && flip_valid;
   assign flip_var_id_o     = flip_valid_o ? flip_var : '0;
   assign flip_value_o      = flip_valid_o && flip_value;
   assign busy_o            = (state != IDLE);
   assign push_ready_o      = (state == IDLE) && !full;
   assign current_level_o   = level;
   assign depth_o           = depth;
   assign full_o            = full;
   assign overflow_o        = overflow;

endmodule

// File: tb/tb_bcp_trail_controller.sv
// Directed bench for bcp_trail_controller: a small trail model fills a queue of expected unassigns per backtrack.
module tb_bcp_trail_controller;
   import bcp_pkg::*;

   logic                             clk_i = 1'b0;
   logic                             rst_i;
   logic                             push_valid_i;
   logic [VARIABLE_ENCODING_LEN-1:0] push_var_id_i;
   logic                             push_value_i;
   logic                             push_is_decision_i;
   logic                             push_ready_o;
   logic                             backtrack_req_i;
   logic [LEVEL_LEN-1:0]             backtrack_level_i;
   logic                             unassign_valid_o;
   logic [VARIABLE_ENCODING_LEN-1:0] unassign_var_id_o;
   logic                             backtrack_done_o;
   logic                             flip_valid_o;
   logic [VARIABLE_ENCODING_LEN-1:0] flip_var_id_o;
   logic                             flip_value_o;
   logic                             busy_o;
   logic [LEVEL_LEN-1:0]             current_level_o;
   logic [DEPTH_LEN-1:0]             depth_o;
   logic                             full_o;
   logic                             overflow_o;

   bcp_trail_controller dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .push_valid_i       (push_valid_i),
      .push_var_id_i      (push_var_id_i),
      .push_value_i       (push_value_i),
      .push_is_decision_i (push_is_decision_i),
      .push_ready_o       (push_ready_o),
      .backtrack_req_i    (backtrack_req_i),
      .backtrack_level_i  (backtrack_level_i),
      .unassign_valid_o   (unassign_valid_o),
      .unassign_var_id_o  (unassign_var_id_o),
      .backtrack_done_o   (backtrack_done_o),
      .flip_valid_o       (flip_valid_o),
      .flip_var_id_o      (flip_var_id_o),
      .flip_value_o       (flip_value_o),
      .busy_o             (busy_o),
      .current_level_o    (current_level_o),
      .depth_o            (depth_o),
      .full_o             (full_o),
      .overflow_o         (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int var_id;
      bit value;
      bit dec;
      int lvl;
   } m_entry_t;

   int       checks   = 0;
   int       failures = 0;
   m_entry_t m_trail[$];
   int       m_level  = 0;
   bit       m_ovf    = 1'b0;
   int       exp_q[$];
   bit       exp_flip_valid;
   int       exp_flip_var;
   bit       exp_flip_value;
   int       exp_done_cycle;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic model_push(input int v, input bit val, input bit d);
      if (m_trail.size() < TRAIL_DEPTH && !(d && m_level == FORMULA_MAX_VARIABLE)) begin
         if (d) m_level++;
         m_trail.push_back('{v, val, d, m_level});
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic model_backtrack(input int t);
      m_entry_t e;
      exp_q.delete();
      exp_flip_valid = 1'b0;
      while (m_trail.size() > 0 && m_trail[$].lvl > t) begin
         e = m_trail.pop_back();
         exp_q.push_back(e.var_id);
         if (e.dec) begin
            exp_flip_valid = 1'b1;
            exp_flip_var   = e.var_id;
            exp_flip_value = e.value;
         end
      end
      exp_done_cycle = exp_q.size() + 2;
      if (t < m_level) m_level = t;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_level"},    current_level_o, m_level);
      chk({tag, "_depth"},    depth_o,         m_trail.size());
      chk({tag, "_full"},     full_o,          m_trail.size() == TRAIL_DEPTH);
      chk({tag, "_overflow"}, overflow_o,      m_ovf);
      chk({tag, "_busy"},     busy_o,          0);
      chk({tag, "_ready"},    push_ready_o,    m_trail.size() < TRAIL_DEPTH);
   endtask

   // Follows one backtrack from cycle 1 until the done pulse; optionally pushes during the first POP cycle.
   task automatic monitor(input bit inject);
      int cyc  = 1;
      int seen = 0;
      bit done_seen = 1'b0;
      while (!done_seen && cyc < 40) begin
         if (inject && cyc == 1) begin
            push_valid_i       = 1'b1;
            push_var_id_i      = 5'd11;
            push_is_decision_i = 1'b0;
            m_ovf              = 1'b1;
         end
         if (unassign_valid_o) begin
            chk("unassign_cycle", cyc, seen + 1);
            if (exp_q.size() > 0) chk("unassign_var", unassign_var_id_o, exp_q.pop_front());
            else                  chk("unassign_extra", unassign_valid_o, 0);
            seen++;
         end
         if (backtrack_done_o) begin
            done_seen = 1'b1;
            chk("done_cycle", cyc, exp_done_cycle);
            chk("flip_valid", flip_valid_o, exp_flip_valid);
            if (exp_flip_valid) begin
               chk("flip_var",   flip_var_id_o, exp_flip_var);
               chk("flip_value", flip_value_o,  exp_flip_value);
            end
         end else begin
            chk("flip_outside_done", flip_valid_o, 0);
         end
         step();
         push_valid_i = 1'b0;
         cyc++;
      end
      if (!done_seen) chk("done_timeout", backtrack_done_o, 1);
   endtask

   task automatic drive(input bit p, input int v, input bit val, input bit d,
                        input bit b, input int t, input bit inject);
      push_valid_i       = p;
      push_var_id_i      = VARIABLE_ENCODING_LEN'(v);
      push_value_i       = val;
      push_is_decision_i = d;
      backtrack_req_i    = b;
      backtrack_level_i  = LEVEL_LEN'(t);
      if (p) model_push(v, val, d);
      if (b) model_backtrack(t);
      step();
      push_valid_i    = 1'b0;
      backtrack_req_i = 1'b0;
      if (b) monitor(inject);
      check_state(b ? "after_bt" : "after_push");
   endtask

   initial begin
      rst_i              = 1'b1;
      push_valid_i       = 1'b0;
      push_var_id_i      = '0;
      push_value_i       = 1'b0;
      push_is_decision_i = 1'b0;
      backtrack_req_i    = 1'b0;
      backtrack_level_i  = '0;
      repeat (2) step();
      chk("rst_unassign", unassign_valid_o, 0);
      chk("rst_done",     backtrack_done_o, 0);
      chk("rst_flip",     flip_valid_o,     0);
      chk("rst_busy",     busy_o,           0);
      chk("rst_level",    current_level_o,  0);
      chk("rst_depth",    depth_o,          0);
      chk("rst_full",     full_o,           0);
      chk("rst_overflow", overflow_o,       0);
      rst_i = 1'b0;
      step();
      chk("rst_ready", push_ready_o, 1);

      // Two levels of assignments, then unwind level 2 and then everything.
      drive(1, 3, 1, 1, 0, 0, 0);
      drive(1, 5, 0, 0, 0, 0, 0);
      drive(1, 7, 0, 1, 0, 0, 0);
      drive(1, 2, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 1, 0);
      drive(0, 0, 0, 0, 1, 0, 0);

      // Target above the current level: nothing popped.
      drive(1, 4, 1, 1, 0, 0, 0);
      drive(1, 6, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 4, 0);

      // Push together with the request, and a push during POP that must be dropped.
      drive(1, 9, 1, 0, 1, 1, 1);

      // Reset in the middle of a three-entry pop.
      drive(1, 8, 0, 1, 0, 0, 0);
      drive(1, 10, 1, 0, 0, 0, 0);
      drive(1, 12, 1, 1, 0, 0, 0);
      backtrack_req_i   = 1'b1;
      backtrack_level_i = 5'd1;
      step();
      backtrack_req_i = 1'b0;
      chk("midrst_unassign1", unassign_var_id_o, 12);
      step();
      chk("midrst_unassign2", unassign_var_id_o, 10);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      m_trail.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      chk("midrst_unassign", unassign_valid_o, 0);
      chk("midrst_done",     backtrack_done_o, 0);
      chk("midrst_flip",     flip_valid_o,     0);
      check_state("midrst");
      for (int i = 0; i < 3; i++) begin
         step();
         chk("midrst_no_done", backtrack_done_o, 0);
         chk("midrst_no_pop",  unassign_valid_o, 0);
      end

      // Fill the trail, overfill by one, then backtrack: overflow stays sticky.
      for (int i = 1; i <= TRAIL_DEPTH; i++) drive(1, i, i[0], 1, 0, 0, 0);
      drive(1, 21, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 18, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcp_trail_controller.md
Name: bcp_trail_controller

Overview:
- Assignment-trail and backtrack sequencer for the BCP accelerator.
- Records every decision and implication broadcast to the clause modules as a LIFO trail tagged with a decision level.
- On a backtrack-to-level request, pops entries above the target one per cycle and drives per-variable unassign strobes to the clause-module array, so the CPU no longer replays assignments.
- Sits between the top-level op FSM (push on PROPAGATE_DECISIONS / PROPAGATE_IMPLICATIONS, request on BACKTRACK) and the clause modules.

Parameters:
- FORMULA_MAX_VARIABLE, 20, highest variable id (ids 1..20; 0 unused).
- VARIABLE_ENCODING_LEN, $clog2(FORMULA_MAX_VARIABLE+1), variable id width (5).
- TRAIL_DEPTH, FORMULA_MAX_VARIABLE, trail entries; one per assigned variable.
- LEVEL_LEN, $clog2(FORMULA_MAX_VARIABLE+1), decision-level width (5).
- DEPTH_LEN, $clog2(TRAIL_DEPTH+1), occupancy counter width (5).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- push_valid_i  in  1  record one assignment this cycle.
- push_var_id_i  in  VARIABLE_ENCODING_LEN  assigned variable.
- push_value_i  in  1  assigned polarity.
- push_is_decision_i  in  1  1 = decision (opens new level), 0 = implication.
- push_ready_o  out  1  state==IDLE && !full_o.
- backtrack_req_i  in  1  start backtrack (sampled in IDLE only).
- backtrack_level_i  in  LEVEL_LEN  target level to keep.
- unassign_valid_o  out  1  clear variable in clause modules this cycle.
- unassign_var_id_o  out  VARIABLE_ENCODING_LEN  variable being cleared.
- backtrack_done_o  out  1  one-cycle completion pulse.
- flip_valid_o  out  1  a decision was popped; valid with done pulse.
- flip_var_id_o  out  VARIABLE_ENCODING_LEN  lowest-level decision popped.
- flip_value_o  out  1  polarity it had (CPU retries the inverse).
- busy_o  out  1  state != IDLE.
- current_level_o  out  LEVEL_LEN  current decision level.
- depth_o  out  DEPTH_LEN  trail occupancy.
- full_o  out  1  depth_o == TRAIL_DEPTH.
- overflow_o  out  1  sticky: a push was dropped.

Behaviour:
- Reset: all outputs 0, depth 0, level 0, state IDLE, trail contents don't-care. Reset mid-pop aborts immediately with no done pulse.
- Entry format: {var_id, value, is_decision, level}.
- Push (IDLE, push_valid_i, !full):
  - Decision: level <= level+1; entry.level = level+1.
  - Implication: entry.level = level.
  - Write at index depth; depth += 1. All updates at the same edge.
- Dropped push: push_valid_i while full or not IDLE is discarded and sets overflow_o; overflow_o clears only on reset.
- Level saturates at FORMULA_MAX_VARIABLE. A decision push at that level is dropped and sets overflow_o.
- FSM IDLE -> POP -> DONE -> IDLE.
  - IDLE: backtrack_req_i latches target and clears flip state; next state POP. Push and request in the same cycle: push is accepted first, and POP sees the new entry.
  - POP: if depth>0 and top.level>target, then unassign_valid_o=1 with unassign_var_id_o=top.var_id (outputs from registers only, no input comb path), depth -= 1. If the top entry is a decision, latch flip_var_id/value and flip_valid. Otherwise next state DONE.
  - DONE: backtrack_done_o=1 for one cycle; level <= min(target, level); flip outputs valid this cycle only (0 otherwise); next state IDLE.
- Timing: request in cycle 0 with k entries above target gives unassigns in cycles 1..k, no pop in cycle k+1, done in cycle k+2.
- target >= level: zero pops, done in cycle 2, level unchanged, flip_valid_o=0.
- backtrack_req_i outside IDLE is ignored (not queued).
- Empty trail: POP exits immediately; no underflow.

Decomposition:
- Shared package bcp_pkg:
  - VARIABLE_ENCODING_LEN / LEVEL_LEN localparams.
  - trail_entry_t packed struct.
  - trail_state_t enum {IDLE, POP, DONE}.
- One sub-module, bcp_trail_stack: register-array LIFO with push, pop, top-read, depth and full. The controller owns the FSM, level tracking and flip capture.

Test Plan:
- Push dec(3,1), imp(5,0), dec(7,0), imp(2,1), then backtrack to level 1 -> unassign 2 then 7 in cycles 1-2, done in cycle 4, flip=(7,0), level 1, depth 2.
- Backtrack to 0 after the case above -> unassign 5, then 3; flip=(3,1); depth 0; level 0.
- Backtrack with target 4 at level 2 -> no unassign, done in cycle 2, flip_valid_o=0, state unchanged.
- Fill 20 entries, push one more -> full_o=1, push dropped, overflow_o=1 and stays set after a backtrack.
- Push and backtrack_req in the same IDLE cycle -> the pushed entry is popped first if its level exceeds the target. A push during POP is dropped and sets overflow.
- Assert rst_i in the middle of a 3-entry pop -> next cycle all outputs 0, no done pulse, depth 0.
